adder_share_arbiter: RTL and testbench
======================================

ADDER_SHARE_ARBITER -- requirements
Module: adder_share_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; no other clock or reset inputs.
REQ-002 Ports SHALL be:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- req0  input  1  requester 0 operation request
- a0, b0  input  3 each  requester 0 operands
- cin0  input  1  requester 0 carry-in
- req1  input  1  requester 1 operation request
- a1, b1  input  3 each  requester 1 operands
- cin1  input  1  requester 1 carry-in
- gnt0  output  1  one-cycle grant to requester 0
- gnt1  output  1  one-cycle grant to requester 1
- busy  output  1  high while state is not IDLE
- rsp_valid  output  1  one-cycle result strobe
- rsp_id  output  1  requester served by the current result (0 or 1)
- rsp_sum  output  3  result, (a + b + cin) mod 8

Function
REQ-003 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-004 IDLE with req0 or req1 high at a clock edge SHALL go to EXEC, latch the winner's a, b, cin and id, and assert that requester's gnt for exactly the next cycle.
REQ-005 EXEC SHALL feed the latched operands to the single shared 3-bit ripple adder, then go to RESP at the next edge and register the sum.
REQ-006 In RESP, rsp_valid SHALL be 1 for exactly one cycle, with rsp_sum and rsp_id valid; RESP SHALL then return to IDLE unconditionally.
REQ-007 Timing SHALL be: request sampled at edge E0 -> gnt high in E0..E1 -> rsp_valid high in E1..E2.
REQ-008 The maximum issue rate SHALL be one operation per 3 cycles.
REQ-009 Requests SHALL be sampled only in IDLE; req levels in EXEC and RESP SHALL be ignored.
REQ-010 A requester SHALL hold req and operands until its gnt; a req still high in IDLE after its RESP SHALL count as a new request.
REQ-011 Operand changes after the grant edge SHALL NOT affect rsp_sum.
REQ-012 Arbitration SHALL be round-robin:
- a single request wins;
- if both request, the requester not granted last wins;
- a 1-bit last_id register SHALL update on every grant.
REQ-013 gnt0 and gnt1 SHALL never be high together.
REQ-014 rsp_sum SHALL hold its last value outside RESP.
REQ-015 Carry-out SHALL be discarded: the sum wraps modulo 8, e.g. 7+1+0 gives 0 and 7+7+1 gives 7.

Reset
REQ-016 With rst_n low at a clock edge, the state SHALL become IDLE and gnt0, gnt1, busy, rsp_valid, rsp_id and rsp_sum SHALL all be 0.
REQ-017 Reset SHALL set last_id to 1, so that requester 0 wins the first tie.
REQ-018 Reset during EXEC or RESP SHALL abort the operation; no rsp_valid for it SHALL be produced after reset.

Configuration
REQ-019 The macro ADDER_ARB_FIXED_PRIO_EN SHALL select the arbitration policy:
- defined: fixed priority, requester 0 always wins a tie, and last_id is not implemented;
- undefined: round-robin per REQ-012.

Structure
REQ-020 A shared package SHALL hold:
- the state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2);
- the operand width constant OP_W=3.
REQ-021 The block SHALL instantiate exactly one sub-module, three_bits_adder, as the shared datapath; the block SHALL contain no other adder logic.

Verification
REQ-022 Single request: req0=1, a0=3, b0=2, cin0=1 -> gnt0 one cycle later, then rsp_valid=1, rsp_id=0, rsp_sum=6.
REQ-023 Round-robin tie: req0 and req1 held high for 4 operations after reset -> grants 0,1,0,1; with ADDER_ARB_FIXED_PRIO_EN defined -> 0,0,0,0.
REQ-024 Wrap-around: a1=7, b1=7, cin1=1 -> rsp_sum=7, rsp_id=1; a0=7, b0=1, cin0=0 -> rsp_sum=0.
REQ-025 Operand change: a0 changed from 2 to 5 in the cycle after gnt0 -> rsp_sum uses a0=2.
REQ-026 Mid-operation reset: rst_n low for one edge while in EXEC -> next cycle all outputs 0, busy=0, and no rsp_valid follows.
REQ-027 Request during busy: req1 rises while in EXEC -> no gnt1 until the bench has returned to IDLE; gnt1 is issued exactly 3 cycles after the preceding gnt.

Source files
------------

// File: rtl/adder_share_arbiter_pkg.sv
// Shared definitions for the adder-sharing arbiter: FSM encoding and operand width.
package adder_share_arbiter_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/adder_share_arbiter_adder.sv
// three_bits_adder: 3-bit ripple-carry adder; the final carry-out is not produced.
module three_bits_adder
  import adder_share_arbiter_pkg::*;
(
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  input  logic            cin,
  output logic [OP_W-1:0] sum
);

  logic c1;
  logic c2;

  assign c1 = (a[0] & b[0]) | (cin & (a[0] ^ b[0]));
  assign c2 = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));

  assign sum = {a[2] ^ b[2] ^ c2, a[1] ^ b[1] ^ c1, a[0] ^ b[0] ^ cin};

endmodule

// File: rtl/adder_share_arbiter.sv
// Two-requester arbiter sharing one 3-bit adder (IDLE -> EXEC -> RESP).
// Macro ADDER_ARB_FIXED_PRIO_EN selects fixed priority; default is round-robin.
module adder_share_arbiter
  import adder_share_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0,
  input  logic [OP_W-1:0] a0,
  input  logic [OP_W-1:0] b0,
  input  logic            cin0,
  input  logic            req1,
  input  logic [OP_W-1:0] a1,
  input  logic [OP_W-1:0] b1,
  input  logic            cin1,
  output logic            gnt0,
  output logic            gnt1,
  output logic            busy,
  output logic            rsp_valid,
  output logic            rsp_id,
  output logic [OP_W-1:0] rsp_sum
);

  state_t state;
  state_t state_nx;

  logic            load;
  logic            win_id;
  logic [OP_W-1:0] op_a;
  logic [OP_W-1:0] op_b;
  logic            op_cin;
  logic            op_id;
  logic [OP_W-1:0] add_sum;

`ifdef ADDER_ARB_FIXED_PRIO_EN
  assign win_id = ~req0;
`else
  logic last_id;

  // On a tie the requester not granted last wins; a single request always wins.
  always_comb begin
    win_id = 1'b0;
    if (req0 && req1) win_id = ~last_id;
    else if (req1)    win_id = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)    last_id <= 1'b1;
    else if (load) last_id <= win_id;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    load      = 1'b0;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    rsp_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          load     = 1'b1;
          state_nx = EXEC;
        end
      end
      EXEC: begin
        gnt0     = ~op_id;
        gnt1     = op_id;
        state_nx = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a    <= '0;
      op_b    <= '0;
      op_cin  <= 1'b0;
      op_id   <= 1'b0;
      rsp_sum <= '0;
      rsp_id  <= 1'b0;
    end else begin
      if (load) begin
        op_a   <= win_id ? a1 : a0;
        op_b   <= win_id ? b1 : b0;
        op_cin <= win_id ? cin1 : cin0;
        op_id  <= win_id;
      end
      if (state == EXEC) begin
        rsp_sum <= add_sum;
        rsp_id  <= op_id;
      end
    end
  end

  three_bits_adder u_adder (
    .a   (op_a),
    .b   (op_b),
    .cin (op_cin),
    .sum (add_sum)
  );

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed self-checking bench for adder_share_arbiter; outputs sampled on falling edges.
module tb_adder_share_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, cin0, cin1;
  logic [2:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, busy, rsp_valid, rsp_id;
  logic [2:0] rsp_sum;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adder_share_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .a0        (a0),
    .b0        (b0),
    .cin0      (cin0),
    .req1      (req1),
    .a1        (a1),
    .b1        (b1),
    .cin1      (cin1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum)
  );

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_gnt0"}, {2'b0, gnt0}, 3'd0);
    chk({tag, "_gnt1"}, {2'b0, gnt1}, 3'd0);
    chk({tag, "_busy"}, {2'b0, busy}, 3'd0);
    chk({tag, "_rsp_valid"}, {2'b0, rsp_valid}, 3'd0);
    chk({tag, "_rsp_id"}, {2'b0, rsp_id}, 3'd0);
    chk({tag, "_rsp_sum"}, rsp_sum, 3'd0);
  endtask

  // Called at a falling edge with the bench idle; runs one complete operation.
  task automatic run_op(input string tag, input logic r0, input logic r1,
                        input logic exp_id, input logic [2:0] exp_sum);
    req0 = r0;
    req1 = r1;
    @(negedge clk);
    chk({tag, "_gnt0"}, {2'b0, gnt0}, {2'b0, ~exp_id});
    chk({tag, "_gnt1"}, {2'b0, gnt1}, {2'b0, exp_id});
    chk({tag, "_busy"}, {2'b0, busy}, 3'd1);
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    chk({tag, "_rsp_valid"}, {2'b0, rsp_valid}, 3'd1);
    chk({tag, "_rsp_id"}, {2'b0, rsp_id}, {2'b0, exp_id});
    chk({tag, "_rsp_sum"}, rsp_sum, exp_sum);
    chk({tag, "_gnt_off"}, {1'b0, gnt0, gnt1}, 3'd0);
    @(negedge clk);
    chk({tag, "_idle_busy"}, {2'b0, busy}, 3'd0);
    chk({tag, "_idle_valid"}, {2'b0, rsp_valid}, 3'd0);
    chk({tag, "_hold_sum"}, rsp_sum, exp_sum);
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; a0 = '0; b0 = '0; cin0 = 1'b0;
    req1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_idle_zero("reset");
    rst_n = 1'b1;

    // Single request: 3+2+1 = 6
    a0 = 3'd3; b0 = 3'd2; cin0 = 1'b1;
    run_op("single", 1'b1, 1'b0, 1'b0, 3'd6);

    // Tie after a fresh reset: requester 0 first, then alternate (round-robin)
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    a0 = 3'd1; b0 = 3'd1; cin0 = 1'b0;
    a1 = 3'd2; b1 = 3'd2; cin1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef ADDER_ARB_FIXED_PRIO_EN
      run_op($sformatf("tie%0d", k), 1'b1, 1'b1, 1'b0, 3'd2);
`else
      run_op($sformatf("tie%0d", k), 1'b1, 1'b1, k[0], k[0] ? 3'd5 : 3'd2);
`endif
    end

    // Wrap-around modulo 8
    a1 = 3'd7; b1 = 3'd7; cin1 = 1'b1;
    run_op("wrap1", 1'b0, 1'b1, 1'b1, 3'd7);
    a0 = 3'd7; b0 = 3'd1; cin0 = 1'b0;
    run_op("wrap0", 1'b1, 1'b0, 1'b0, 3'd0);

    // Operand change after grant must not affect the result: 2+1+0 = 3
    a0 = 3'd2; b0 = 3'd1; cin0 = 1'b0; req0 = 1'b1;
    @(negedge clk);
    chk("opchg_gnt0", {2'b0, gnt0}, 3'd1);
    a0 = 3'd5; req0 = 1'b0;
    @(negedge clk);
    chk("opchg_valid", {2'b0, rsp_valid}, 3'd1);
    chk("opchg_sum", rsp_sum, 3'd3);
    @(negedge clk);

    // Reset while in EXEC aborts the operation
    a0 = 3'd1; b0 = 3'd1; req0 = 1'b1;
    @(negedge clk);
    chk("abort_gnt0", {2'b0, gnt0}, 3'd1);
    rst_n = 1'b0; req0 = 1'b0;
    @(negedge clk);
    chk_idle_zero("abort");
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("abort_novalid%0d", k), {2'b0, rsp_valid}, 3'd0);
      chk($sformatf("abort_nobusy%0d", k), {2'b0, busy}, 3'd0);
    end

    // req1 rising during EXEC is ignored until IDLE; gnt1 comes 3 cycles after gnt0
    a0 = 3'd1; b0 = 3'd0; cin0 = 1'b0;
    a1 = 3'd4; b1 = 3'd2; cin1 = 1'b0;
    req0 = 1'b1;
    @(negedge clk);
    chk("busyreq_gnt0", {2'b0, gnt0}, 3'd1);
    req0 = 1'b0; req1 = 1'b1;
    @(negedge clk);
    chk("busyreq_resp_gnt1", {2'b0, gnt1}, 3'd0);
    chk("busyreq_resp_sum", rsp_sum, 3'd1);
    @(negedge clk);
    chk("busyreq_idle_gnt1", {2'b0, gnt1}, 3'd0);
    chk("busyreq_idle_busy", {2'b0, busy}, 3'd0);
    @(negedge clk);
    chk("busyreq_gnt1", {2'b0, gnt1}, 3'd1);
    chk("busyreq_gnt0_off", {2'b0, gnt0}, 3'd0);
    req1 = 1'b0;
    @(negedge clk);
    chk("busyreq_rsp_id", {2'b0, rsp_id}, 3'd1);
    chk("busyreq_rsp_sum", rsp_sum, 3'd6);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  always @(negedge clk) begin
    if (rst_n && gnt0 && gnt1) begin
      checks++;
      failures++;
      $error("FAIL gnt_exclusive observed=%0d%0d expected=not both", gnt0, gnt1);
    end
  end

endmodule
